// File: rtl/dma_controller_2ch.sv
// Two-channel byte-wide memory-to-memory DMA over a shared single-port memory (async read, clocked write).
// Each byte costs one READ and one WRITE cycle; ch0 has fixed priority and transfers are never preempted.
module dma_controller_2ch #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ch0_start,
    input  logic [ADDR_WIDTH-1:0] ch0_src,
    input  logic [ADDR_WIDTH-1:0] ch0_dst,
    input  logic [7:0]            ch0_size,
    input  logic                  ch1_start,
    input  logic [ADDR_WIDTH-1:0] ch1_src,
    input  logic [ADDR_WIDTH-1:0] ch1_dst,
    input  logic [7:0]            ch1_size,
    output logic                  mem_read_en,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  ch0_done,
    output logic                  ch1_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t                       state_q;
    logic                         cur_ch_q;
    logic [ADDR_WIDTH-1:0]        src_q;
    logic [ADDR_WIDTH-1:0]        dst_q;
    logic [7:0]                   cnt_q;
    logic [DATA_WIDTH-1:0]        buf_q;
    logic                         rd_en_q;
    logic                         wr_en_q;
    logic [ADDR_WIDTH-1:0]        addr_q;
    logic [1:0]                   done_q;

    logic [1:0]                   pend_q;
    logic [1:0][ADDR_WIDTH-1:0]   req_src_q;
    logic [1:0][ADDR_WIDTH-1:0]   req_dst_q;
    logic [1:0][7:0]              req_size_q;

    logic [1:0]                   start;
    logic [1:0][ADDR_WIDTH-1:0]   start_src;
    logic [1:0][ADDR_WIDTH-1:0]   start_dst;
    logic [1:0][7:0]              start_size;
    logic [1:0]                   active;
    logic [1:0]                   accept;
    logic                         grant_vld;
    logic                         grant_ch;
    logic [ADDR_WIDTH-1:0]        src_d;
    logic [ADDR_WIDTH-1:0]        dst_d;
    logic [7:0]                   cnt_d;

    assign start      = {ch1_start, ch0_start};
    assign start_src  = {ch1_src, ch0_src};
    assign start_dst  = {ch1_dst, ch0_dst};
    assign start_size = {ch1_size, ch0_size};

    // A channel is busy from the start edge until its done edge; starts in that window are dropped.
    assign active[0] = (state_q != IDLE) && (cur_ch_q == 1'b0);
    assign active[1] = (state_q != IDLE) && (cur_ch_q == 1'b1);
    assign accept    = start & ~pend_q & ~active;

    assign grant_vld = |pend_q;
    assign grant_ch  = ~pend_q[0];

    assign src_d = src_q + ADDR_WIDTH'(1);
    assign dst_d = dst_q + ADDR_WIDTH'(1);
    assign cnt_d = cnt_q - 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_ch_q   <= 1'b0;
            src_q      <= '0;
            dst_q      <= '0;
            cnt_q      <= '0;
            buf_q      <= '0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            done_q     <= '0;
            pend_q     <= '0;
            req_src_q  <= '0;
            req_dst_q  <= '0;
            req_size_q <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (accept[c]) begin
                    pend_q[c]     <= 1'b1;
                    req_src_q[c]  <= start_src[c];
                    req_dst_q[c]  <= start_dst[c];
                    req_size_q[c] <= start_size[c];
                    done_q[c]     <= 1'b0;
                end
            end

            case (state_q)
                IDLE: begin
                    rd_en_q <= 1'b0;
                    wr_en_q <= 1'b0;
                    addr_q  <= '0;
                    if (grant_vld) begin
                        pend_q[grant_ch] <= 1'b0;
                        cur_ch_q         <= grant_ch;
                        src_q            <= req_src_q[grant_ch];
                        dst_q            <= req_dst_q[grant_ch];
                        cnt_q            <= req_size_q[grant_ch];
                        // Zero-length requests complete at the grant edge without touching memory.
                        if (req_size_q[grant_ch] == 8'd0) begin
                            done_q[grant_ch] <= 1'b1;
                        end else begin
                            state_q <= READ;
                            rd_en_q <= 1'b1;
                            addr_q  <= req_src_q[grant_ch];
                        end
                    end
                end
                READ: begin
                    buf_q   <= mem_read_data;
                    state_q <= WRITE;
                    rd_en_q <= 1'b0;
                    wr_en_q <= 1'b1;
                    addr_q  <= dst_q;
                end
                WRITE: begin
                    src_q   <= src_d;
                    dst_q   <= dst_d;
                    cnt_q   <= cnt_d;
                    wr_en_q <= 1'b0;
                    if (cnt_q == 8'd1) begin
                        done_q[cur_ch_q] <= 1'b1;
                        state_q          <= IDLE;
                        addr_q           <= '0;
                    end else begin
                        state_q <= READ;
                        rd_en_q <= 1'b1;
                        addr_q  <= src_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rd_en_q <= 1'b0;
                    wr_en_q <= 1'b0;
                    addr_q  <= '0;
                end
            endcase
        end
    end

    assign mem_read_en    = rd_en_q;
    assign mem_write_en   = wr_en_q;
    assign mem_addr       = addr_q;
    assign mem_write_data = buf_q;
    assign ch0_done       = done_q[0];
    assign ch1_done       = done_q[1];

endmodule

// File: tb/tb_dma_controller_2ch.sv
// Directed bench: behavioural memory, write scoreboard fed from a shadow copy, done-latency checks.
module tb_dma_controller_2ch;

    logic       clk;
    logic       rst;
    logic       ch0_start;
    logic [7:0] ch0_src;
    logic [7:0] ch0_dst;
    logic [7:0] ch0_size;
    logic       ch1_start;
    logic [7:0] ch1_src;
    logic [7:0] ch1_dst;
    logic [7:0] ch1_size;
    logic       mem_read_en;
    logic       mem_write_en;
    logic [7:0] mem_addr;
    logic [7:0] mem_write_data;
    logic [7:0] mem_read_data;
    logic       ch0_done;
    logic       ch1_done;

    logic [7:0]  mem [256];
    logic [7:0]  ref_mem [256];
    logic        mem_init;
    logic [15:0] exp_q [$];

    int total;
    int passed;
    int rd_cnt;
    int wr_cnt;

    dma_controller_2ch #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .ch0_start      (ch0_start),
        .ch0_src        (ch0_src),
        .ch0_dst        (ch0_dst),
        .ch0_size       (ch0_size),
        .ch1_start      (ch1_start),
        .ch1_src        (ch1_src),
        .ch1_dst        (ch1_dst),
        .ch1_size       (ch1_size),
        .mem_read_en    (mem_read_en),
        .mem_write_en   (mem_write_en),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .ch0_done       (ch0_done),
        .ch1_done       (ch1_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
        end else if (mem_write_en) begin
            mem[mem_addr] <= mem_write_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Every write strobe must match the oldest outstanding expected (addr,data) pair.
    always @(negedge clk) begin
        if (mem_read_en) rd_cnt++;
        if (mem_write_en) begin
            logic [15:0] e;
            wr_cnt++;
            chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("write_addr", 32'(mem_addr), 32'(e[15:8]));
                chk("write_data", 32'(mem_write_data), 32'(e[7:0]));
            end
        end
    end

    task automatic push_expect(input logic [7:0] src, input logic [7:0] dst, input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] a;
            logic [7:0] d;
            a = src + 8'(i);
            d = dst + 8'(i);
            exp_q.push_back({d, ref_mem[a]});
            ref_mem[d] = ref_mem[a];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int ch, input logic [7:0] src, input logic [7:0] dst, input logic [7:0] size);
        if (ch == 0) begin
            ch0_start = 1'b1; ch0_src = src; ch0_dst = dst; ch0_size = size;
        end else begin
            ch1_start = 1'b1; ch1_src = src; ch1_dst = dst; ch1_size = size;
        end
    endtask

    task automatic fire();
        tick();
        ch0_start = 1'b0;
        ch1_start = 1'b0;
    endtask

    // Latencies are counted in edges after the start edge; -1 means never observed.
    task automatic run_edges(input int n, output int l0, output int l1);
        l0 = -1;
        l1 = -1;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (ch0_done && l0 < 0) l0 = k;
            if (ch1_done && l1 < 0) l1 = k;
        end
    endtask

    initial begin
        int l0;
        int l1;
        int rd0;
        int wr0;
        total = 0; passed = 0; rd_cnt = 0; wr_cnt = 0;
        rst = 1'b1; mem_init = 1'b1;
        ch0_start = 1'b0; ch0_src = '0; ch0_dst = '0; ch0_size = '0;
        ch1_start = 1'b0; ch1_src = '0; ch1_dst = '0; ch1_size = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i);

        tick(); tick();
        chk("rst_read_en",  32'(mem_read_en),    32'd0);
        chk("rst_write_en", 32'(mem_write_en),   32'd0);
        chk("rst_addr",     32'(mem_addr),       32'd0);
        chk("rst_wdata",    32'(mem_write_data), 32'd0);
        chk("rst_ch0_done", 32'(ch0_done),       32'd0);
        chk("rst_ch1_done", 32'(ch1_done),       32'd0);
        rst = 1'b0; mem_init = 1'b0;
        tick();

        // Single ch0 copy of two bytes.
        set_req(0, 8'd10, 8'd100, 8'd2);
        push_expect(8'd10, 8'd100, 2);
        fire();
        run_edges(8, l0, l1);
        chk("t1_ch0_latency", 32'(l0), 32'd5);
        chk("t1_ch1_done", 32'(ch1_done), 32'd0);
        chk("t1_mem100", 32'(mem[100]), 32'h0A);
        chk("t1_mem101", 32'(mem[101]), 32'h0B);
        chk("t1_mem102", 32'(mem[102]), 32'd102);

        // Single ch1 copy; ch0 done stays sticky.
        set_req(1, 8'd50, 8'd150, 8'd2);
        push_expect(8'd50, 8'd150, 2);
        fire();
        run_edges(8, l0, l1);
        chk("t2_ch1_latency", 32'(l1), 32'd5);
        chk("t2_ch0_done", 32'(ch0_done), 32'd1);
        chk("t2_mem150", 32'(mem[150]), 32'h32);
        chk("t2_mem151", 32'(mem[151]), 32'h33);

        // Simultaneous starts: ch0 runs to completion, one idle edge, then ch1.
        set_req(0, 8'd10, 8'd100, 8'd3);
        set_req(1, 8'd50, 8'd150, 8'd3);
        push_expect(8'd10, 8'd100, 3);
        push_expect(8'd50, 8'd150, 3);
        fire();
        chk("t3_ch0_cleared", 32'(ch0_done), 32'd0);
        chk("t3_ch1_cleared", 32'(ch1_done), 32'd0);
        run_edges(18, l0, l1);
        chk("t3_ch0_latency", 32'(l0), 32'd7);
        chk("t3_ch1_latency", 32'(l1), 32'd14);
        chk("t3_mem102", 32'(mem[102]), 32'h0C);
        chk("t3_mem152", 32'(mem[152]), 32'h34);

        // Zero-length request completes at the grant edge with no memory traffic.
        rd0 = rd_cnt; wr0 = wr_cnt;
        set_req(0, 8'd5, 8'd200, 8'd0);
        fire();
        run_edges(4, l0, l1);
        chk("t4_ch0_latency", 32'(l0), 32'd1);
        chk("t4_no_reads",  32'(rd_cnt), 32'(rd0));
        chk("t4_no_writes", 32'(wr_cnt), 32'(wr0));

        // Source address wraps past 255.
        set_req(0, 8'd254, 8'h10, 8'd4);
        push_expect(8'd254, 8'h10, 4);
        fire();
        run_edges(12, l0, l1);
        chk("t5_ch0_latency", 32'(l0), 32'd9);
        chk("t5_mem10", 32'(mem[8'h10]), 32'hFE);
        chk("t5_mem11", 32'(mem[8'h11]), 32'hFF);
        chk("t5_mem12", 32'(mem[8'h12]), 32'h00);
        chk("t5_mem13", 32'(mem[8'h13]), 32'h01);

        // Reset after the first committed byte aborts the rest of the transfer.
        set_req(0, 8'd20, 8'd200, 8'd4);
        push_expect(8'd20, 8'd200, 1);
        fire();
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        chk("t6_read_en",  32'(mem_read_en),    32'd0);
        chk("t6_write_en", 32'(mem_write_en),   32'd0);
        chk("t6_addr",     32'(mem_addr),       32'd0);
        chk("t6_wdata",    32'(mem_write_data), 32'd0);
        chk("t6_ch0_done", 32'(ch0_done),       32'd0);
        rst = 1'b0;
        tick();
        chk("t6_mem200", 32'(mem[200]), 32'd20);
        chk("t6_mem201", 32'(mem[201]), 32'd201);
        set_req(0, 8'd30, 8'd210, 8'd1);
        push_expect(8'd30, 8'd210, 1);
        fire();
        run_edges(5, l0, l1);
        chk("t6_restart_latency", 32'(l0), 32'd3);
        chk("t6_mem210", 32'(mem[210]), 32'd30);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dma_controller_2ch.md
# dma_controller_2ch

Two-channel, byte-wide memory-to-memory DMA engine. It sits between two request sources and a single-port memory with asynchronous (combinational) read and clocked write. A requester pulses start with source, destination and length. The block copies the bytes one at a time over the shared memory port and raises a per-channel done flag. Channel 0 has fixed priority over channel 1, and a transfer in progress is never preempted.

## Interface
- ADDR_WIDTH, 8, memory address width; address arithmetic wraps modulo 2^ADDR_WIDTH
- DATA_WIDTH, 8, memory data width
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- ch0_start / ch1_start  in  1  one-cycle request pulse; src/dst/size sampled on the same edge
- ch0_src / ch1_src  in  ADDR_WIDTH  source start address
- ch0_dst / ch1_dst  in  ADDR_WIDTH  destination start address
- ch0_size / ch1_size  in  8  byte count, 0..255
- mem_read_en  out  1  read strobe; memory returns data combinationally
- mem_write_en  out  1  write strobe; memory writes on the next rising edge
- mem_addr  out  ADDR_WIDTH  shared read/write address
- mem_write_data  out  DATA_WIDTH  write data
- mem_read_data  in  DATA_WIDTH  combinational read data for mem_addr
- ch0_done / ch1_done  out  1  sticky completion flag per channel

## Operation
- Each channel has a request register: pending flag, src, dst and size.
- A start pulse loads the request register and sets pending. It also clears that channel's done flag.
- A start is ignored if that channel is already pending or active.
- States are IDLE, READ and WRITE.
- IDLE:
  - If ch0 is pending, grant ch0; otherwise, if ch1 is pending, grant ch1.
  - On grant: clear that channel's pending flag, load working src, dst and remaining count, then go to READ.
  - If the granted size is 0, set that channel's done flag and stay in IDLE. No memory access occurs.
- READ:
  - mem_read_en=1, mem_addr=current src.
  - On the edge: latch mem_read_data into the data buffer, then go to WRITE.
- WRITE:
  - mem_write_en=1, mem_addr=current dst, mem_write_data=buffer.
  - On the edge: src+1, dst+1 (both wrap), count−1.
  - If count reaches 0, set the channel's done flag and go to IDLE; otherwise go to READ.
- Done flag: stays high until the next accepted start on that channel, or until rst.
- While one channel is active, the other channel's start is still accepted into its request register. It is served when the engine returns to IDLE.
- Addresses are unsigned and wrap at 2^ADDR_WIDTH. Overlapping src/dst ranges are copied in ascending address order with no hazard protection.

## Timing
- All outputs reset to 0. Reset state: IDLE, pending flags cleared, done flags cleared, buffer=0.
- rst asserted mid-transfer aborts at that edge. The aborted write does not occur unless it was already committed on an earlier edge. Done is not set.
- Outside READ/WRITE, mem_read_en=0, mem_write_en=0, mem_addr=0, mem_write_data holds the buffer.
- Start sampled at edge E0:
  - E1 grant (IDLE→READ)
  - each byte takes 2 cycles, READ then WRITE
  - last write commits, and done rises, at edge E0+1+2·size
  - example: size=2 gives done high after E5
- Back-to-back: the next pending channel is granted one cycle after the previous transfer's done edge, because one IDLE cycle is always inserted.
- Simultaneous starts on both channels: ch0 completes fully first, then ch1.

## Test plan
- Memory preset mem[i]=i. ch0 src=10, dst=100, size=2 → mem[100]=0x0A, mem[101]=0x0B; ch0_done rises 5 edges after start; mem[102] is unchanged.
- After the previous test, ch1 src=50, dst=150, size=2 → mem[150]=0x32, mem[151]=0x33; ch1_done=1; ch0_done stays 1.
- Both starts on the same edge: ch0 10→100 size 3 and ch1 50→150 size 3 → all ch0 writes precede any ch1 write; ch0_done rises at start+7, ch1_done at start+14. The 14 counts ch0's transfer (edges 1–7), one IDLE-grant edge (8), then 3 bytes × 2 edges (9–14).
- ch0 size=0 → ch0_done rises at the grant edge; no mem_read_en or mem_write_en activity.
- Wrap: ch0 src=254, dst=0x10, size=4 → mem[0x10..0x13]=0xFE, 0xFF, 0x00, 0x01.
- rst asserted after the first byte of a size=4 transfer → outputs 0 on the next cycle; only the first destination byte is written; ch0_done=0; a new start afterward works normally.
